// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants and FSM state encoding for the serial
//               segment driver. Frame geometry (groups, byte width, frame
//               length) and the 3-bit state codes used by seg_serial_drv.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int N_GROUPS   = 4;
    localparam int BYTE_W     = 8;
    localparam int FRAME_BITS = N_GROUPS * BYTE_W;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] c_ST_CLEAR = 3'd1;
    localparam logic [ST_W-1:0] c_ST_FETCH = 3'd2;
    localparam logic [ST_W-1:0] c_ST_SHIFT = 3'd3;
    localparam logic [ST_W-1:0] c_ST_LATCH = 3'd4;
    localparam logic [ST_W-1:0] c_ST_DONE  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/seg_tick_div.sv
`default_nettype none
// ============================================================================
// Module      : seg_tick_div
// Description : Phase counter for the serial driver. Counts 0..CLK_DIV-1 and
//               raises o_phase_end on the last count of each phase. i_clr
//               restarts the count so every FSM state begins a fresh phase.
// Ports       : clk         - system clock
//               rst_n       - asynchronous active-low reset
//               i_clr       - restart the phase (FSM state change)
//               o_phase_end - high on the final cycle of a phase
// Revision    : 1.0 - initial release
// ============================================================================
module seg_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_phase_end
);

    localparam int                 c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_phase_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_phase_end = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/seg_serial_drv.sv
`default_nettype none
// ============================================================================
// Module      : seg_serial_drv
// Description : Walks Scan through groups 0..3, captures the segment byte the
//               map stage returns for each group and shifts the 32-bit frame
//               MSB-first into the board shift-register chain, then pulses
//               the output latch. One frame per start request.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               start        - frame request
//               Seg_map[7:0] - segment byte for the current Scan
//               Scan[2:0]    - group index to the map stage ([2] tied 0)
//               busy, done   - frame in progress / one-cycle completion pulse
//               seg_clk, seg_dt, seg_en, seg_clr_n - board chain pins
// Options     : define SEG_AUTO_REFRESH_EN to restart a frame automatically
//               after REFRESH_CYCLES idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_serial_drv
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 4
`ifdef SEG_AUTO_REFRESH_EN
    ,
    parameter int REFRESH_CYCLES = 100000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] Seg_map,
    output logic [2:0]        Scan,
    output logic              busy,
    output logic              done,
    output logic              seg_clk,
    output logic              seg_dt,
    output logic              seg_en,
    output logic              seg_clr_n
);

    localparam int c_BIT_W = $clog2(BYTE_W);

    logic [ST_W-1:0]    r_state;
    logic [ST_W-1:0]    w_next;
    logic               w_phase_end;
    logic               w_start_req;
    logic [1:0]         r_group;
    logic [c_BIT_W-1:0] r_bit;
    logic               r_half;      // 0: seg_clk low phase, 1: high phase
    logic [BYTE_W-1:0]  r_shreg;
    logic               r_dt_last;   // keeps seg_dt stable outside SHIFT

    seg_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_next != r_state),
        .o_phase_end (w_phase_end)
    );

`ifdef SEG_AUTO_REFRESH_EN
    localparam int c_IDLE_W = $clog2(REFRESH_CYCLES + 1);

    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic                w_refresh;

    // Counts only while idle; any other state (including DONE) or an
    // external start clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (r_state != c_ST_IDLE || start) begin
            r_idle_cnt <= '0;
        end else if (!w_refresh) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign w_refresh   = (r_state == c_ST_IDLE) &&
                         (r_idle_cnt == c_IDLE_W'(REFRESH_CYCLES - 1));
    assign w_start_req = start | w_refresh;
`else
    assign w_start_req = start;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_start_req) w_next = c_ST_CLEAR;
            c_ST_CLEAR: if (w_phase_end) w_next = c_ST_FETCH;
            c_ST_FETCH: w_next = c_ST_SHIFT;
            c_ST_SHIFT: begin
                if (w_phase_end && r_half && r_bit == '0) begin
                    w_next = (r_group == 2'(N_GROUPS - 1)) ? c_ST_LATCH : c_ST_FETCH;
                end
            end
            c_ST_LATCH: if (w_phase_end) w_next = c_ST_DONE;
            // A start still held during DONE chains straight into the next
            // frame, so back-to-back frames are separated by the DONE cycle.
            c_ST_DONE:  w_next = start ? c_ST_CLEAR : c_ST_IDLE;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_group   <= '0;
            r_bit     <= '0;
            r_half    <= 1'b0;
            r_shreg   <= '0;
            r_dt_last <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dt_last <= seg_dt;
            case (r_state)
                c_ST_CLEAR: r_group <= '0;
                c_ST_FETCH: begin
                    r_shreg <= Seg_map;
                    r_bit   <= c_BIT_W'(BYTE_W - 1);
                    r_half  <= 1'b0;
                end
                c_ST_SHIFT: begin
                    if (w_phase_end) begin
                        r_half <= ~r_half;
                        // End of the high phase is the seg_clk falling edge.
                        if (r_half) begin
                            r_shreg <= {r_shreg[BYTE_W-2:0], 1'b0};
                            r_bit   <= r_bit - 1'b1;
                            if (r_bit == '0 && r_group != 2'(N_GROUPS - 1)) begin
                                r_group <= r_group + 1'b1;
                            end
                        end
                    end
                end
                c_ST_DONE:  r_group <= '0;
                default:    ;
            endcase
        end
    end

    assign Scan      = {1'b0, r_group};
    assign busy      = (r_state == c_ST_CLEAR) || (r_state == c_ST_FETCH) ||
                       (r_state == c_ST_SHIFT) || (r_state == c_ST_LATCH);
    assign done      = (r_state == c_ST_DONE);
    assign seg_clk   = (r_state == c_ST_SHIFT) && r_half;
    assign seg_dt    = (r_state == c_ST_SHIFT) ? r_shreg[BYTE_W-1] : r_dt_last;
    assign seg_en    = (r_state == c_ST_LATCH);
    assign seg_clr_n = (r_state != c_ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_seg_serial_drv.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_serial_drv
// Description : Self-checking bench for seg_serial_drv. Two instances
//               (CLK_DIV=4 and CLK_DIV=1) share a map table; frames are
//               observed at the pins and compared with the frame expected
//               from the map contents and the frame timing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_serial_drv;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] map_mem [4];

    logic [7:0] seg_map0, seg_map1;
    logic [2:0] scan0, scan1;
    logic       busy0, busy1, done0, done1, sclk0, sclk1, sdt0, sdt1;
    logic       sen0, sen1, sclr0, sclr1;

    always #5 clk = ~clk;

    assign seg_map0 = map_mem[scan0[1:0]];
    assign seg_map1 = map_mem[scan1[1:0]];

    seg_serial_drv #(.CLK_DIV(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .Seg_map(seg_map0),
        .Scan(scan0), .busy(busy0), .done(done0), .seg_clk(sclk0),
        .seg_dt(sdt0), .seg_en(sen0), .seg_clr_n(sclr0)
    );

    seg_serial_drv #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .Seg_map(seg_map1),
        .Scan(scan1), .busy(busy1), .done(done1), .seg_clk(sclk1),
        .seg_dt(sdt1), .seg_en(sen1), .seg_clr_n(sclr1)
    );

    // View of whichever instance is under test.
    logic [2:0] scan_m;
    logic       busy_m, done_m, clk_m, dt_m, en_m, clrn_m;
    assign scan_m = sel ? scan1 : scan0;
    assign busy_m = sel ? busy1 : busy0;
    assign done_m = sel ? done1 : done0;
    assign clk_m  = sel ? sclk1 : sclk0;
    assign dt_m   = sel ? sdt1  : sdt0;
    assign en_m   = sel ? sen1  : sen0;
    assign clrn_m = sel ? sclr1 : sclr0;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          m_busy, m_rises, m_done, m_en, m_en_early, m_clr, m_scan_bad;
    int          m_min_per, m_max_per, m_timeout;
    logic [31:0] m_bits;
    logic [8:0]  m_rst_snap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic new_map();
        for (int i = 0; i < 4; i++) map_mem[i] = 8'($urandom);
    endtask

    function automatic logic [31:0] exp_frame();
        return {map_mem[0], map_mem[1], map_mem[2], map_mem[3]};
    endfunction

    // Requests one frame and observes pins until done (or timeout).
    // retrig_at: cycle to pulse start again; rst_at: cycle to assert reset.
    task automatic run_frame(input int retrig_at, input int rst_at);
        logic pclk;
        int   last_rise;
        pclk = 1'b0; last_rise = 0;
        m_busy = 0; m_rises = 0; m_done = 0; m_en = 0; m_en_early = 0;
        m_clr = 0; m_scan_bad = 0; m_min_per = 1000; m_max_per = 0;
        m_timeout = 0; m_bits = '0;
        set_start(1'b1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            if (busy_m) m_busy++;
            if (!clrn_m) m_clr++;
            if (en_m) begin
                m_en++;
                if (m_rises != 32) m_en_early++;
            end
            if (clk_m && !pclk) begin
                m_bits = {m_bits[30:0], dt_m};
                if (int'(scan_m) != m_rises / 8) m_scan_bad++;
                if (m_rises % 8 != 0) begin
                    if (cyc - last_rise < m_min_per) m_min_per = cyc - last_rise;
                    if (cyc - last_rise > m_max_per) m_max_per = cyc - last_rise;
                end
                last_rise = cyc;
                m_rises++;
            end
            pclk = clk_m;
            if (done_m) begin
                m_done++;
                return;
            end
            if (cyc == 0 || cyc == retrig_at + 1) set_start(1'b0);
            if (cyc == retrig_at) set_start(1'b1);
            if (cyc == rst_at) begin
                #2 rst_n = 1'b0;
                #1 m_rst_snap = {scan_m, busy_m, done_m, clk_m, dt_m, en_m, clrn_m};
                idle(2);
                rst_n = 1'b1;
                return;
            end
        end
        m_timeout = 1;
    endtask

    task automatic check_frame(input string tag, input int div);
        check({tag, ".timeout"},  m_timeout, 0);
        check({tag, ".rises"},    m_rises, 32);
        check({tag, ".bits"},     m_bits, exp_frame());
        check({tag, ".busy"},     m_busy, 66 * div + 4);
        check({tag, ".done"},     m_done, 1);
        check({tag, ".en"},       m_en, div);
        check({tag, ".en_early"}, m_en_early, 0);
        check({tag, ".clr"},      m_clr, div);
        check({tag, ".scan"},     m_scan_bad, 0);
        check({tag, ".per_min"},  m_min_per, 2 * div);
        check({tag, ".per_max"},  m_max_per, 2 * div);
    endtask

    initial begin
        int          busy_after, frames, gaps, hscan_bad, hrises, hdone_seen;
        logic        hpclk, started;
        logic [31:0] hbits [3];

        map_mem[0] = 8'hA5; map_mem[1] = 8'h3C; map_mem[2] = 8'hFF; map_mem[3] = 8'h00;
        idle(3);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            check($sformatf("reset%0d", s),
                  {23'd0, scan_m, busy_m, done_m, clk_m, dt_m, en_m, clrn_m}, 32'h001);
        end
        sel = 1'b0;
        rst_n = 1'b1;
        idle(3);

        // Directed frame, then random maps, at CLK_DIV=4.
        run_frame(-10, -10);
        check_frame("div4_fixed", 4);
        idle(1);
        check("div4_done_single", {31'd0, done_m}, 0);
        for (int k = 0; k < 2; k++) begin
            new_map();
            idle(5);
            run_frame(-10, -10);
            check_frame($sformatf("div4_rand%0d", k), 4);
        end

        // CLK_DIV=1 instance.
        sel = 1'b1;
        new_map();
        idle(3);
        run_frame(-10, -10);
        check_frame("div1", 1);
        sel = 1'b0;

        // Start re-pulsed mid-frame is ignored and not queued.
        new_map();
        idle(3);
        run_frame(50, -10);
        check_frame("retrig", 4);
        busy_after = 0;
        for (int c = 0; c < 30; c++) begin
            idle(1);
            if (busy_m || done_m) busy_after++;
        end
        check("retrig.no_queue", busy_after, 0);

        // Reset during group 1, then a clean frame.
        new_map();
        run_frame(-10, 120);
        check("rst.snapshot", {23'd0, m_rst_snap}, 32'h001);
        check("rst.no_en", m_en, 0);
        check("rst.no_done", m_done, 0);
        idle(2);
        run_frame(-10, -10);
        check_frame("after_rst", 4);

        // Start held for three back-to-back frames.
        new_map();
        idle(3);
        set_start(1'b1);
        frames = 0; gaps = 0; hscan_bad = 0; hrises = 0; hdone_seen = 0;
        hpclk = 1'b0; started = 1'b0;
        for (int i = 0; i < 3; i++) hbits[i] = '0;
        for (int cyc = 0; cyc < 1200 && frames < 3; cyc++) begin
            idle(1);
            if (busy_m) started = 1'b1;
            if (started && !busy_m && !done_m) gaps++;
            if (clk_m && !hpclk) begin
                hbits[frames] = {hbits[frames][30:0], dt_m};
                if (int'(scan_m) != hrises / 8) hscan_bad++;
                hrises++;
            end
            hpclk = clk_m;
            if (done_m) begin
                hdone_seen++;
                frames++;
                hrises = 0;
                if (frames == 3) set_start(1'b0);
            end
        end
        set_start(1'b0);
        check("hold.frames", hdone_seen, 3);
        check("hold.gaps", gaps, 0);
        check("hold.scan", hscan_bad, 0);
        for (int i = 0; i < 3; i++) check($sformatf("hold.bits%0d", i), hbits[i], exp_frame());
        idle(3);
        check("hold.idle_after", {31'd0, busy_m}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
